// File: rtl/lfsr_fetch.sv
// rtl/lfsr_fetch.sv - LFSR peripheral fetch initiator with output FIFO (optional check: LFSR_FETCH_CHECK_EN)
module lfsr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] SEED_RST = 32'hBABECAFE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        seed_load,
  input  logic [31:0] seed_val,
  input  logic [7:0]  burst_len,
  output logic        busy,
  output logic        done,
  output logic [3:0]  reg_seed_we,
  output logic [31:0] reg_seed_di,
  output logic        reg_dat_re,
  input  logic [31:0] reg_dat_do,
  input  logic        reg_dat_wait,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err_stuck
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_READ = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic          first_q, first_d;
  logic [31:0]   seed_q, seed_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  logic          pop;
  logic          free;
  logic          rd_ok;
  logic          push;

  // A slot counts as free if one is empty now or the head leaves this cycle
  assign out_valid  = (cnt_q != '0);
  assign pop        = out_valid & out_ready;
  assign free       = (cnt_q != FULL_CNT) | pop;
  // Request only while words remain and the FIFO can take the answer; since
  // stalls never push, this stays high for the whole of a stalled request
  assign rd_ok      = (state_q == ST_READ) & (rem_q != 8'd0) & free;
  assign reg_dat_re = rd_ok;
  assign push       = rd_ok & ~reg_dat_wait;
  assign out_data   = out_valid ? mem_q[rd_q] : 32'd0;

  // Control state register; reset restores first-run so the next burst reseeds
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
      first_q <= 1'b1;
      seed_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      seed_q  <= seed_d;
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    first_d     = first_q;
    seed_d      = seed_q;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    reg_seed_we = 4'b0000;
    reg_seed_di = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d  = burst_len;
          seed_d = seed_load ? seed_val : SEED_RST;
          if (seed_load || first_q) begin
            state_d = ST_SEED;
          end else if (burst_len == 8'd0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_SEED: begin
        reg_seed_we = 4'b1111;
        reg_seed_di = seed_q;
        first_d     = 1'b0;
        state_d     = (rem_q == 8'd0) ? ST_FIN : ST_READ;
      end
      ST_READ: begin
        if (rem_q == 8'd0) begin
          state_d = ST_FIN;
        end else if (push) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + PTR_ONE;
      end
      if (pop) begin
        rd_q <= rd_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= reg_dat_do;
    end
  end

`ifdef LFSR_FETCH_CHECK_EN
  logic [31:0] prev_q;
  logic        err_q;

  // Flag a word that repeats its predecessor or is zero; reseeding restarts the history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_SEED) begin
        prev_q <= 32'd0;
      end else if (push) begin
        prev_q <= reg_dat_do;
        if ((reg_dat_do == prev_q) || (reg_dat_do == 32'd0)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err_stuck = err_q;
`else
  assign err_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_fetch.sv
// tb/tb_lfsr_fetch.sv - scoreboard bench for lfsr_fetch with scripted/random responder
module tb_lfsr_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] SEED_RST = 32'hBABECAFE;
`ifdef LFSR_FETCH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        start;
  logic        seed_load;
  logic [31:0] seed_val;
  logic [7:0]  burst_len;
  logic        busy;
  logic        done;
  logic [3:0]  reg_seed_we;
  logic [31:0] reg_seed_di;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        err_stuck;

  lfsr_fetch #(.DEPTH(DEPTH), .SEED_RST(SEED_RST)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .seed_load   (seed_load),
    .seed_val    (seed_val),
    .burst_len   (burst_len),
    .busy        (busy),
    .done        (done),
    .reg_seed_we (reg_seed_we),
    .reg_seed_di (reg_seed_di),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_do  (reg_dat_do),
    .reg_dat_wait(reg_dat_wait),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .err_stuck   (err_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] script_q[$];

  bit rand_wait  = 1'b0;
  bit rand_ready = 1'b0;
  bit ready_val  = 1'b1;
  bit force_wait = 1'b0;
  int wait_hold  = 0;

  int          we_cnt, re_cnt, push_cnt, done_cnt, re_drop;
  logic [31:0] last_di;
  bit          prev_re_wait;

  bit          first_run_m = 1'b1;
  logic [31:0] prev_m      = 32'd0;
  bit          err_m       = 1'b0;
  bit          exp_we_m;
  logic [31:0] exp_di_m;
  int          cur_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_counters();
    we_cnt = 0; re_cnt = 0; push_cnt = 0; done_cnt = 0; re_drop = 0;
    last_di = 32'd0; prev_re_wait = 1'b0;
  endtask

  // Responder and consumer drive their inputs on the falling edge
  always @(negedge clk) begin
    reg_dat_wait = force_wait || (wait_hold > 0) || (rand_wait && ($urandom_range(0, 2) == 0));
    out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    reg_dat_do   = (resp_q.size() != 0) ? resp_q[0] : 32'hDEAD0000;
  end

  // Monitor: observes the settled cycle and scores every FIFO pop
  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (reg_seed_we != 4'b0000) begin
        we_cnt++;
        last_di = reg_seed_di;
        check("seed_we_mask", {28'd0, reg_seed_we}, 32'hF);
      end
      if (reg_dat_re) begin
        re_cnt++;
        if (reg_dat_wait) begin
          if (wait_hold > 0) wait_hold--;
        end else begin
          push_cnt++;
          if (resp_q.size() != 0) void'(resp_q.pop_front());
        end
      end
      if (prev_re_wait && !reg_dat_re) re_drop++;
      prev_re_wait = reg_dat_re && reg_dat_wait;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%h expected=none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // Builds the expected word stream and seeding behaviour, then pulses start
  task automatic issue(input bit sl, input logic [31:0] sv, input int len);
    logic [31:0] w;
    bit seeded;
    seeded = sl || first_run_m;
    exp_we_m = seeded;
    exp_di_m = sl ? sv : SEED_RST;
    if (seeded) begin
      first_run_m = 1'b0;
      prev_m = 32'd0;
    end
    for (int i = 0; i < len; i++) begin
      w = (script_q.size() != 0) ? script_q.pop_front() : $urandom;
      exp_q.push_back(w);
      resp_q.push_back(w);
      if (w == prev_m || w == 32'd0) err_m = 1'b1;
      prev_m = w;
    end
    cur_len = len;
    @(negedge clk);
    clear_counters();
    start = 1'b1; seed_load = sl; seed_val = sv; burst_len = 8'(len);
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0; burst_len = 8'($urandom);
  endtask

  task automatic finish_burst(input string tag, input int exp_re);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk); #2; n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    @(negedge clk); #2;
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    rand_ready = 1'b0; ready_val = 1'b1; rand_wait = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk); #2; n++;
    end
    check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_fifo_empty"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_we_cycles"}, 32'(we_cnt), 32'(exp_we_m));
    if (exp_we_m) check({tag, "_seed_di"}, last_di, exp_di_m);
    check({tag, "_pushes"}, 32'(push_cnt), 32'(cur_len));
    check({tag, "_re_dropped"}, 32'(re_drop), 32'd0);
    if (exp_re >= 0) check({tag, "_re_cycles"}, 32'(re_cnt), 32'(exp_re));
    check({tag, "_err_stuck"}, {31'd0, err_stuck}, {31'd0, CHK & err_m});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_we"}, {28'd0, reg_seed_we}, 32'd0);
    check({tag, "_di"}, reg_seed_di, 32'd0);
    check({tag, "_re"}, {31'd0, reg_dat_re}, 32'd0);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_err"}, {31'd0, err_stuck}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int len;
    bit sl;
    resetn = 1'b0; start = 1'b0; seed_load = 1'b0; seed_val = 32'd0; burst_len = 8'd0;
    clear_counters();
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    resetn = 1'b1;

    // First run without seed_load still seeds with the default seed
    issue(1'b0, 32'h0, 2);
    finish_burst("first_run", 2);

    // Explicit seed, three words in order
    script_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    issue(1'b1, 32'hBABECAFE, 3);
    finish_burst("seeded3", 3);

    // Stalled first read: four wait cycles then completion
    wait_hold = 4;
    issue(1'b0, 32'h0, 2);
    finish_burst("stall", 6);

    // Back-pressure: FIFO fills to DEPTH, then resumes
    ready_val = 1'b0;
    issue(1'b0, 32'h0, 6);
    n = 0;
    while (push_cnt < DEPTH && n < 200) begin @(negedge clk); #2; n++; end
    repeat (3) @(negedge clk);
    #2;
    check("full_pushes", 32'(push_cnt), 32'(DEPTH));
    check("full_re_low", {31'd0, reg_dat_re}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    ready_val = 1'b1;
    finish_burst("full", 6);

    // Zero-length burst without seeding: done one cycle after start
    issue(1'b0, 32'h0, 0);
    #2;
    check("len0_done_next", {31'd0, done}, 32'd1);
    finish_burst("len0", 0);

    // Repeated word
    script_q = '{32'h00001234, 32'h00001234};
    issue(1'b1, 32'h5A5A5A5A, 2);
    finish_burst("repeat", 2);

    // Reset during a stalled read with words buffered
    ready_val = 1'b0;
    issue(1'b0, 32'h0, 3);
    n = 0;
    while (push_cnt < 2 && n < 200) begin @(negedge clk); #2; n++; end
    force_wait = 1'b1;
    n = 0;
    while (!(reg_dat_re && reg_dat_wait) && n < 50) begin @(negedge clk); #2; n++; end
    check("midread_re_seen", {31'd0, reg_dat_re}, 32'd1);
    resetn = 1'b0;
    #1;
    check_all_zero("midread_reset");
    exp_q.delete(); resp_q.delete();
    force_wait = 1'b0; ready_val = 1'b1;
    first_run_m = 1'b1; prev_m = 32'd0; err_m = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    issue(1'b0, 32'h0, 2);
    finish_burst("after_reset", 2);

    // Randomized bursts with random stalls and back-pressure
    for (int b = 0; b < 10; b++) begin
      sl  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 9);
      rand_wait = 1'b1; rand_ready = 1'b1;
      issue(sl, $urandom, len);
      if (len >= 3) begin
        #2;
        check("rand_busy_mid", {31'd0, busy}, 32'd1);
        start = 1'b1; seed_load = 1'b1; seed_val = 32'hFFFF0000; burst_len = 8'd7;
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
      end
      finish_burst("rand", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
